// File: rtl/ctrl_pkg.sv
// Shared control-bundle type, opcode constants and field encodings
// for the RV32I decode stage and its combinational decoder.
package ctrl_pkg;

  localparam int CTRL_W = 20;

  typedef struct packed {
    logic [2:0] imm_type;
    logic [3:0] alu_op;
    logic [2:0] branch_cond;
    logic       data_read_en;
    logic       data_write_en;
    logic [2:0] data_size;
    logic [1:0] mem_to_reg;
    logic       reg_write_en;
    logic       alu_b_src;
    logic       alu_a_src;
  } ctrl_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_U = 3'd5;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  localparam logic [2:0] BC_NONE = 3'b010;
  localparam logic [2:0] BC_JUMP = 3'b011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_LUI = 4'b1001;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational RV32I decoder: instr -> ctrl_t, sign-extended imm, illegal.
// Ports: i_instr (32), o_ctrl (ctrl_t), o_imm (XLEN), o_illegal.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm32;
  logic        w_ill;
  ctrl_t       w_c;

  assign w_op = i_instr[6:0];
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];

  always_comb begin
    w_c = '0;
    w_c.branch_cond = BC_NONE;
    w_ill = 1'b0;
    unique case (1'b1)
      (w_op == OPC_OP_IMM): begin
        w_c.imm_type = IMM_I;
        w_c.alu_b_src = 1'b1;
        w_c.reg_write_en = 1'b1;
        // only shifts use funct7; ADDI with imm[10]=1 stays ADD
        w_c.alu_op = (w_f3 == 3'b101) ? {w_f7[5], w_f3}
                                      : {1'b0, w_f3};
        w_ill = ((w_f3 == 3'b001) && (w_f7 != F7_BASE)) ||
                ((w_f3 == 3'b101) && (w_f7 != F7_BASE) &&
                 (w_f7 != F7_ALT));
      end
      (w_op == OPC_OP): begin
        w_c.imm_type = IMM_R;
        w_c.reg_write_en = 1'b1;
        w_c.alu_op = {w_f7[5], w_f3};
        w_ill = ((w_f7 != F7_BASE) && (w_f7 != F7_ALT)) ||
                ((w_f7 == F7_ALT) && (w_f3 != 3'b000) &&
                 (w_f3 != 3'b101));
      end
      (w_op == OPC_LOAD): begin
        w_c.imm_type = IMM_I;
        w_c.alu_b_src = 1'b1;
        w_c.reg_write_en = 1'b1;
        w_c.mem_to_reg = M2R_MEM;
        w_c.data_read_en = 1'b1;
        w_c.data_size = w_f3;
        w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) ||
                (w_f3 == 3'b111);
      end
      (w_op == OPC_STORE): begin
        w_c.imm_type = IMM_S;
        w_c.alu_b_src = 1'b1;
        w_c.data_write_en = 1'b1;
        w_c.data_size = w_f3;
        w_ill = (w_f3 >= 3'b011);
      end
      (w_op == OPC_BRANCH): begin
        w_c.imm_type = IMM_B;
        w_c.alu_a_src = 1'b1;
        w_c.alu_b_src = 1'b1;
        w_c.branch_cond = w_f3;
        w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      (w_op == OPC_JAL): begin
        w_c.imm_type = IMM_J;
        w_c.alu_a_src = 1'b1;
        w_c.alu_b_src = 1'b1;
        w_c.reg_write_en = 1'b1;
        w_c.mem_to_reg = M2R_PC4;
        w_c.branch_cond = BC_JUMP;
      end
      (w_op == OPC_JALR): begin
        w_c.imm_type = IMM_I;
        w_c.alu_b_src = 1'b1;
        w_c.reg_write_en = 1'b1;
        w_c.mem_to_reg = M2R_PC4;
        w_c.branch_cond = BC_JUMP;
        w_ill = (w_f3 != 3'b000);
      end
      (w_op == OPC_LUI): begin
        w_c.imm_type = IMM_U;
        w_c.alu_op = ALU_LUI;
        w_c.alu_b_src = 1'b1;
        w_c.reg_write_en = 1'b1;
      end
      (w_op == OPC_AUIPC): begin
        w_c.imm_type = IMM_U;
        w_c.alu_a_src = 1'b1;
        w_c.alu_b_src = 1'b1;
        w_c.reg_write_en = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // illegal bundles must have no architectural side effect
    if (w_ill) begin
      w_c.reg_write_en = 1'b0;
      w_c.data_read_en = 1'b0;
      w_c.data_write_en = 1'b0;
      w_c.branch_cond = BC_NONE;
    end
  end

  always_comb begin
    unique case (w_c.imm_type)
      IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25],
                        i_instr[11:7]};
      IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31],
                        i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
      default: w_imm32 = '0;
    endcase
  end

  always_comb begin
    o_imm = {XLEN{w_imm32[31]}};
    o_imm[31:0] = w_imm32;
  end

  assign o_ctrl = w_c;
  assign o_illegal = w_ill;

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode pipeline stage: decodes, then buffers in an output reg + optional skid.
// Ports: in_* valid/ready upstream, out_* bundle downstream, flush, illegal_count.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [19:0]      out_ctrl,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [14:0]      out_regs,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int BW = CTRL_W + 2 * XLEN + 16;

  ctrl_t            w_ctrl;
  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;
  logic [BW-1:0]    w_in_data;
  logic             w_acc;
  logic             w_free;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic [BW-1:0]    r_out_data;
  logic [BW-1:0]    r_skid_data;
  logic [CNT_W-1:0] r_cnt;

  ctrl_decode_comb #(.XLEN(XLEN)) u_dec (
    .i_instr  (in_instr),
    .o_ctrl   (w_ctrl),
    .o_imm    (w_imm),
    .o_illegal(w_illegal)
  );

  assign w_in_data = {w_ctrl, w_imm, in_pc, in_instr[11:7],
                      in_instr[19:15], in_instr[24:20], w_illegal};

  assign in_ready = (SKID != 0) ? !r_skid_valid
                                : (!r_out_valid || out_ready);
  assign w_acc  = in_valid && in_ready && !flush;
  assign w_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_free) begin
      // skid full implies in_ready=0, so no accept competes here
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_acc;
        if (w_acc) r_out_data <= w_in_data;
      end
    end else if (w_acc) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_acc && w_illegal && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign {out_ctrl, out_imm, out_pc, out_regs, out_illegal} = r_out_data;
  assign illegal_count = r_cnt;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed testbench for ctrl_decode_stage (XLEN=32, SKID=1, CNT_W=8).
// Each scenario task drives stimulus and checks results inline.
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_ctrl;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [14:0] out_regs;
  logic        out_illegal;
  logic [7:0]  illegal_count;

  int tests = 0;
  int failed = 0;

  ctrl_decode_stage #(.XLEN(32), .SKID(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_imm(out_imm), .out_pc(out_pc),
    .out_regs(out_regs), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ctl(input int it, input int op,
      input int bc, input int rd, input int wr, input int sz,
      input int m2r, input int rwe, input int b, input int a);
    return {it[2:0], op[3:0], bc[2:0], rd[0], wr[0], sz[2:0],
            m2r[1:0], rwe[0], b[0], a[0]};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin failed++;
      $display("FAIL rst_valid got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin failed++;
      $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    tests++; if (illegal_count !== 8'd0) begin failed++;
      $display("FAIL rst_count got %0d want 0", illegal_count); end
    tests++; if (out_ctrl !== 20'd0 || out_pc !== 32'd0) begin
      failed++;
      $display("FAIL rst_data got ctrl %h pc %h want 0", out_ctrl,
               out_pc); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin failed++;
      $display("FAIL addi_valid got %0b want 1", out_valid); end
    tests++; if (out_imm !== 32'hFFFFFFFF) begin failed++;
      $display("FAIL addi_imm got %h want ffffffff", out_imm); end
    tests++; if (out_ctrl[16:13] !== 4'b0000) begin failed++;
      $display("FAIL addi_aluop got %b want 0000", out_ctrl[16:13]); end
    tests++; if (out_ctrl[19:17] !== 3'd1) begin failed++;
      $display("FAIL addi_immtype got %0d want 1", out_ctrl[19:17]); end
    tests++; if (out_ctrl[2] !== 1'b1) begin failed++;
      $display("FAIL addi_rwe got %0b want 1", out_ctrl[2]); end
    tests++; if (out_pc !== 32'h100) begin failed++;
      $display("FAIL addi_pc got %h want 100", out_pc); end
    tests++; if (out_ctrl !== ctl(1, 0, 2, 0, 0, 0, 0, 1, 1, 0)) begin
      failed++; $display("FAIL addi_ctrl got %h want %h", out_ctrl,
                         ctl(1, 0, 2, 0, 0, 0, 0, 1, 1, 0)); end
    tests++; if (out_regs !== {5'd1, 5'd2, 5'd31}) begin failed++;
      $display("FAIL addi_regs got %h want %h", out_regs,
               {5'd1, 5'd2, 5'd31}); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin failed++;
      $display("FAIL addi_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_branch();
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'h00208463; in_pc = 32'h140;
    @(posedge clk); #1;
    in_instr = 32'h0020A463; in_pc = 32'h144;
    tests++; if (out_imm !== 32'd8) begin failed++;
      $display("FAIL beq_imm got %h want 8", out_imm); end
    tests++; if (out_ctrl !== ctl(3, 0, 0, 0, 0, 0, 0, 0, 1, 1)) begin
      failed++; $display("FAIL beq_ctrl got %h want %h", out_ctrl,
                         ctl(3, 0, 0, 0, 0, 0, 0, 0, 1, 1)); end
    tests++; if (out_illegal !== 1'b0) begin failed++;
      $display("FAIL beq_illegal got %0b want 0", out_illegal); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (out_illegal !== 1'b1 || out_pc !== 32'h144) begin
      failed++; $display("FAIL beq010_illegal got %0b pc %h want 1 144",
                         out_illegal, out_pc); end
    tests++; if (out_ctrl[12:10] !== 3'b010) begin failed++;
      $display("FAIL beq010_bc got %b want 010", out_ctrl[12:10]); end
    tests++; if (illegal_count !== 8'd1) begin failed++;
      $display("FAIL beq010_count got %0d want 1", illegal_count); end
  endtask

  task automatic test_decode();
    logic [31:0] di [8];
    logic [19:0] dc [8];
    logic [31:0] dm [8];
    logic        dl [8];
    di[0] = 32'h40000093; dc[0] = ctl(1, 0, 2, 0, 0, 0, 0, 1, 1, 0);
    dm[0] = 32'h00000400; dl[0] = 1'b0;
    di[1] = 32'h402081B3; dc[1] = ctl(0, 8, 2, 0, 0, 0, 0, 1, 0, 0);
    dm[1] = 32'h0;        dl[1] = 1'b0;
    di[2] = 32'h123450B7; dc[2] = ctl(5, 9, 2, 0, 0, 0, 0, 1, 1, 0);
    dm[2] = 32'h12345000; dl[2] = 1'b0;
    di[3] = 32'h0020A223; dc[3] = ctl(2, 0, 2, 0, 1, 2, 0, 0, 1, 0);
    dm[3] = 32'h4;        dl[3] = 1'b0;
    di[4] = 32'hFFDFF0EF; dc[4] = ctl(4, 0, 3, 0, 0, 0, 2, 1, 1, 1);
    dm[4] = 32'hFFFFFFFC; dl[4] = 1'b0;
    di[5] = 32'hFF80A283; dc[5] = ctl(1, 0, 2, 1, 0, 2, 1, 1, 1, 0);
    dm[5] = 32'hFFFFFFF8; dl[5] = 1'b0;
    di[6] = 32'h4030D093; dc[6] = ctl(1, 13, 2, 0, 0, 0, 0, 1, 1, 0);
    dm[6] = 32'h00000403; dl[6] = 1'b0;
    di[7] = 32'h402091B3; dc[7] = ctl(0, 9, 2, 0, 0, 0, 0, 0, 0, 0);
    dm[7] = 32'h0;        dl[7] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = di[i]; in_pc = 32'h400 + 32'(4 * i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++; if (out_ctrl !== dc[i] || out_valid !== 1'b1) begin
        failed++; $display("FAIL dec%0d_ctrl got %h v%0b want %h", i,
                           out_ctrl, out_valid, dc[i]); end
      tests++; if (out_imm !== dm[i]) begin failed++;
        $display("FAIL dec%0d_imm got %h want %h", i, out_imm, dm[i]); end
      tests++; if (out_illegal !== dl[i]) begin failed++;
        $display("FAIL dec%0d_ill got %0b want %0b", i, out_illegal,
                 dl[i]); end
    end
    tests++; if (illegal_count !== 8'd2) begin failed++;
      $display("FAIL dec_count got %0d want 2", illegal_count); end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int oidx = 0;
    int drop = -1;
    for (int cyc = 0; cyc < 30 && oidx < 4; cyc++) begin
      @(posedge clk); #1;
      in_valid = (idx < 4);
      in_instr = 32'h00100093 + (32'(idx) << 20);
      in_pc = 32'h200 + 32'(4 * idx);
      out_ready = (cyc >= 4);
      @(negedge clk);
      if (!in_ready && drop < 0) drop = idx;
      if (out_valid && !out_ready) begin
        tests++; if (out_pc !== 32'h200) begin failed++;
          $display("FAIL b2b_hold cyc%0d got %h want 200", cyc,
                   out_pc); end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (out_pc !== 32'h200 + 32'(4 * oidx) ||
            out_imm !== 32'(oidx + 1)) begin
          failed++; $display("FAIL b2b_out%0d got pc %h imm %h want %h %h",
            oidx, out_pc, out_imm, 32'h200 + 32'(4 * oidx), oidx + 1);
        end
        oidx++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    tests++; if (drop !== 2) begin failed++;
      $display("FAIL b2b_drop got %0d accepts want 2", drop); end
    tests++; if (oidx !== 4) begin failed++;
      $display("FAIL b2b_count got %0d outputs want 4", oidx); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
    @(posedge clk); #1;
    in_pc = 32'h304;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failed++; $display("FAIL flush_full got rdy %0b v %0b want 0 1",
                         in_ready, out_valid); end
    flush = 1'b1; in_pc = 32'h308;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++; $display("FAIL flush_clear got v %0b rdy %0b want 0 1",
                         out_valid, in_ready); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    tests++; if (out_valid !== 1'b0) begin failed++;
      $display("FAIL flush_drop got %0b want 0", out_valid); end
    tests++; if (illegal_count !== 8'd2) begin failed++;
      $display("FAIL flush_count got %0d want 2", illegal_count); end
  endtask

  task automatic test_saturate();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0;
    in_pc = 32'h500;
    repeat (260) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests++; if (illegal_count !== 8'd255) begin failed++;
      $display("FAIL sat_count got %0d want 255", illegal_count); end
    tests++; if (out_illegal !== 1'b1 || out_ctrl[12:10] !== 3'b010 ||
                 out_ctrl[2] !== 1'b0) begin
      failed++; $display("FAIL sat_ctrl got ill %0b ctrl %h", out_illegal,
                         out_ctrl); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h600;
    @(posedge clk); #1;
    in_pc = 32'h604;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failed++; $display("FAIL arst_pre got v %0b rdy %0b want 1 0",
                         out_valid, in_ready); end
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || illegal_count !== 8'd0) begin
      failed++; $display("FAIL arst_clear got v %0b cnt %0d want 0 0",
                         out_valid, illegal_count); end
    tests++; if (out_pc !== 32'd0 || in_ready !== 1'b1) begin
      failed++; $display("FAIL arst_data got pc %h rdy %0b want 0 1",
                         out_pc, in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_decode();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
